// File: rtl/saturn_bus_sequencer_if.sv
// Handshake and nibble-bus signals between the control unit, the read consumer and the Saturn bus.
interface saturn_bus_sequencer_if #(
  parameter int PROG_DEPTH = 16,
  parameter int RLEN_W     = 5
);
  logic                          i_clk_en;
  logic                          i_debug_cycle;
  logic [3:0]                    i_phases;
  logic                          i_prog_valid;
  logic [4:0]                    i_prog_data;
  logic                          o_prog_ready;
  logic                          i_read_req;
  logic [RLEN_W-1:0]             i_read_len;
  logic                          o_rd_valid;
  logic [3:0]                    o_rd_nibble;
  logic                          i_rd_ready;
  logic                          o_bus_clk_en;
  logic                          o_bus_is_data;
  logic [3:0]                    o_bus_nibble_out;
  logic [3:0]                    i_bus_nibble_in;
  logic                          o_busy;
  logic                          o_error;
  logic [$clog2(PROG_DEPTH):0]   o_prog_level;

  modport master (
    output i_clk_en, i_debug_cycle, i_phases, i_prog_valid, i_prog_data, i_read_req,
           i_read_len, i_rd_ready, i_bus_nibble_in,
    input  o_prog_ready, o_rd_valid, o_rd_nibble, o_bus_clk_en, o_bus_is_data,
           o_bus_nibble_out, o_busy, o_error, o_prog_level
  );
  modport slave (
    input  i_clk_en, i_debug_cycle, i_phases, i_prog_valid, i_prog_data, i_read_req,
           i_read_len, i_rd_ready, i_bus_nibble_in,
    output o_prog_ready, o_rd_valid, o_rd_nibble, o_bus_clk_en, o_bus_is_data,
           o_bus_nibble_out, o_busy, o_error, o_prog_level
  );
endinterface

// File: rtl/saturn_bus_sequencer.sv
// Program FIFO feeding the 4-phase Saturn nibble bus, with counted read bursts into a read FIFO.
module saturn_bus_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int RD_DEPTH   = 16,
  parameter int RLEN_W     = 5
) (
  input logic i_clk,
  input logic i_reset_n,
  saturn_bus_sequencer_if.slave bus
);
  localparam int PA = $clog2(PROG_DEPTH);
  localparam int RA = $clog2(RD_DEPTH);

  typedef enum logic [1:0] {K_IDLE, K_WRITE, K_READ} kind_t;

  logic [4:0]        pmem [PROG_DEPTH];
  logic [PA-1:0]     pwr, prd;
  logic [PA:0]       plvl;
  logic [3:0]        rmem [RD_DEPTH];
  logic [RA-1:0]     rwr, rrd;
  logic [RA:0]       rcnt;
  logic [RLEN_W-1:0] rd_rem;
  kind_t             kind;

  logic en, ph0, ph1, ph2;
  logic p_push, p_pop, r_push, r_pop, rd_go, req_ok;

  assign en     = bus.i_clk_en && !bus.i_debug_cycle;
  assign ph0    = en && (bus.i_phases == 4'b0001);
  assign ph1    = en && (bus.i_phases == 4'b0010);
  assign ph2    = en && (bus.i_phases == 4'b0100);
  assign p_push = bus.i_prog_valid && bus.o_prog_ready;
  assign p_pop  = ph0 && (plvl != '0);
  // Reads only get the slot when no write is queued; full read FIFO just defers the strobe.
  assign rd_go  = ph0 && (plvl == '0) && (rd_rem != '0) && (rcnt != (RA+1)'(RD_DEPTH));
  assign r_push = ph1 && (kind == K_READ);
  assign r_pop  = bus.i_rd_ready && (rcnt != '0);
  assign req_ok = bus.i_read_req && (rd_rem == '0);

  assign bus.o_prog_ready = (plvl != (PA+1)'(PROG_DEPTH));
  assign bus.o_prog_level = plvl;
  assign bus.o_rd_valid   = (rcnt != '0);
  assign bus.o_rd_nibble  = rmem[rrd];

  always_ff @(posedge i_clk) begin
    if (p_push) pmem[pwr] <= bus.i_prog_data;
    if (r_push) rmem[rwr] <= bus.i_bus_nibble_in;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwr <= '0; prd <= '0; plvl <= '0;
      rwr <= '0; rrd <= '0; rcnt <= '0;
      rd_rem <= '0;
      kind <= K_IDLE;
      bus.o_bus_clk_en <= 1'b0;
      bus.o_bus_is_data <= 1'b0;
      bus.o_bus_nibble_out <= 4'h0;
      bus.o_busy <= 1'b1;
      bus.o_error <= 1'b0;
    end else begin
      if (p_push) pwr <= pwr + 1'b1;
      if (p_pop)  prd <= prd + 1'b1;
      if (p_push && !p_pop) plvl <= plvl + 1'b1;
      else if (!p_push && p_pop) plvl <= plvl - 1'b1;

      if (r_push) rwr <= rwr + 1'b1;
      if (r_pop)  rrd <= rrd + 1'b1;
      if (r_push && !r_pop) rcnt <= rcnt + 1'b1;
      else if (!r_push && r_pop) rcnt <= rcnt - 1'b1;

      if (req_ok) rd_rem <= bus.i_read_len;
      else if (rd_go) rd_rem <= rd_rem - 1'b1;
      if (bus.i_read_req && !req_ok) bus.o_error <= 1'b1;

      if (ph0) begin
        if (p_pop) begin
          bus.o_bus_nibble_out <= pmem[prd][3:0];
          bus.o_bus_is_data <= !pmem[prd][4];
          bus.o_bus_clk_en <= 1'b1;
          kind <= K_WRITE;
        end else if (rd_go) begin
          bus.o_bus_clk_en <= 1'b1;
          bus.o_bus_is_data <= 1'b1;
          kind <= K_READ;
        end else begin
          kind <= K_IDLE;
        end
      end
      if (ph1) bus.o_bus_clk_en <= 1'b0;
      if (ph2) bus.o_busy <= (plvl != '0) || (rd_rem != '0);
    end
  end
endmodule
